// File: rtl/aespim_pkg.sv
// Shared opcodes, state encoding and sizing for the AES-128 sequencer.
// Imported by aespim_seq_ctrl.
package aespim_pkg;

    localparam int NR_DEFAULT = 10;
    localparam int NUM_WORDS  = 4;
    localparam int KEY_WORDS  = 4 * (NR_DEFAULT + 1);

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_ST   = 6'b000001;
    localparam logic [5:0] OP_ENCF = 6'b000110;

    function automatic logic [5:0] op_enci(input logic [1:0] w);
        return {1'b0, w, 3'b100};
    endfunction

    function automatic logic [5:0] op_encm(input logic [1:0] w);
        return {1'b0, w, 3'b101};
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        INIT  = 3'd2,
        MID   = 3'd3,
        FINAL = 3'd4,
        STORE = 3'd5,
        DONE  = 3'd6
    } aespim_seq_state_e;

endpackage

// File: rtl/aespim_seq_ctrl.sv
// Steps one aespim_accelerator through a full AES-128 block encryption,
// one op per cycle, with round keys prefetched from a synchronous RAM.
module aespim_seq_ctrl
    import aespim_pkg::*;
#(
    parameter int NR     = 10,
    parameter int KEY_AW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [127:0]      pt_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [127:0]      res_o,
    output logic              busy_o,
    output logic [KEY_AW-1:0] key_addr_o,
    input  logic [31:0]       key_rdata_i,
    output logic              acc_start_o,
    output logic [5:0]        acc_op_o,
    output logic [31:0]       acc_data_o,
    input  logic [31:0]       acc_data_i
);

    aespim_seq_state_e state_q, state_d;
    logic [1:0]        w_q, w_d;
    logic [3:0]        r_q, r_d;
    logic [127:0]      pt_q, pt_d;
    logic [127:0]      res_q, res_d;
    logic [KEY_AW-1:0] kaddr_q, kaddr_d;
    logic              cap_vld_q, cap_vld_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic [5:0]        op_q;
    logic [31:0]       data_q;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == DONE) && !cap_vld_q;
    assign res_o       = res_q;
    assign key_addr_o  = kaddr_q;

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        r_d         = r_q;
        pt_d        = pt_q;
        res_d       = res_q;
        kaddr_d     = kaddr_q;
        cap_vld_d   = 1'b0;
        cap_idx_d   = cap_idx_q;
        acc_start_o = 1'b0;
        acc_op_o    = op_q;
        acc_data_o  = data_q;

        // ST data returns one cycle after issue
        if (cap_vld_q) begin
            res_d[{cap_idx_q, 5'b0} +: 32] = acc_data_i;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pt_d    = pt_i;
                    w_d     = 2'd0;
                    r_d     = 4'd0;
                    kaddr_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_start_o = 1'b1;
                acc_op_o    = OP_LD;
                acc_data_o  = pt_q[{w_q, 5'b0} +: 32];
                w_d         = w_q + 2'd1;
                if (w_q == 2'd3) begin
                    kaddr_d = kaddr_q + KEY_AW'(1);
                    state_d = INIT;
                end
            end
            INIT: begin
                acc_start_o = 1'b1;
                acc_op_o    = op_enci(w_q);
                acc_data_o  = key_rdata_i;
                w_d         = w_q + 2'd1;
                kaddr_d     = kaddr_q + KEY_AW'(1);
                if (w_q == 2'd3) begin
                    r_d     = 4'd1;
                    state_d = MID;
                end
            end
            MID: begin
                acc_start_o = 1'b1;
                acc_op_o    = op_encm(w_q);
                acc_data_o  = key_rdata_i;
                w_d         = w_q + 2'd1;
                kaddr_d     = kaddr_q + KEY_AW'(1);
                if (w_q == 2'd3) begin
                    if (r_q == 4'(NR - 1)) begin
                        r_d     = 4'd0;
                        state_d = FINAL;
                    end else begin
                        r_d = r_q + 4'd1;
                    end
                end
            end
            FINAL: begin
                acc_start_o = 1'b1;
                acc_op_o    = OP_ENCF;
                acc_data_o  = key_rdata_i;
                w_d         = w_q + 2'd1;
                // last key address is already out by w=2
                if (w_q < 2'd2) begin
                    kaddr_d = kaddr_q + KEY_AW'(1);
                end
                if (w_q == 2'd3) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                acc_start_o = 1'b1;
                acc_op_o    = OP_ST;
                acc_data_o  = 32'd0;
                w_d         = w_q + 2'd1;
                cap_vld_d   = 1'b1;
                cap_idx_d   = w_q;
                if (w_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_valid_o && res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            w_q       <= 2'd0;
            r_q       <= 4'd0;
            pt_q      <= '0;
            res_q     <= '0;
            kaddr_q   <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= 2'd0;
            op_q      <= 6'd0;
            data_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            r_q       <= r_d;
            pt_q      <= pt_d;
            res_q     <= res_d;
            kaddr_q   <= kaddr_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            op_q      <= acc_op_o;
            data_q    <= acc_data_o;
        end
    end

endmodule

// File: tb/tb_aespim_seq_ctrl.sv
// Bench for aespim_seq_ctrl: behavioural AES accelerator and key RAM,
// scoreboard of known AES-128 vectors, op-trace and handshake scenarios.
module tb_aespim_seq_ctrl;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] pt;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res;
    logic         busy;
    logic [5:0]   key_addr;
    logic [31:0]  key_rdata;
    logic         acc_start;
    logic [5:0]   acc_op;
    logic [31:0]  acc_data;
    logic [31:0]  m_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [127:0] sb[$];
    logic [7:0]   sbox[256];
    logic [31:0]  kram[64];

    logic         trace_en = 1'b0;
    logic [5:0]   t_op[$];
    logic [31:0]  t_data[$];
    logic [5:0]   t_addr[$];

    aespim_seq_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .pt_i        (pt),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res),
        .busy_o      (busy),
        .key_addr_o  (key_addr),
        .key_rdata_i (key_rdata),
        .acc_start_o (acc_start),
        .acc_op_o    (acc_op),
        .acc_data_o  (acc_data),
        .acc_data_i  (m_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) key_rdata <= kram[key_addr];

    always @(negedge clk) begin
        if (trace_en && acc_start) begin
            t_op.push_back(acc_op);
            t_data.push_back(acc_data);
            t_addr.push_back(key_addr);
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] y;
        y = {x, x} << n;
        return y[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // One AES round on a FIPS-ordered 128-bit state; mix=0 for the last round
    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input bit mix);
        logic [7:0]   a[4][4];
        logic [7:0]   b[4][4];
        logic [7:0]   m[4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[r][c] = sbox[s[127-8*(r+4*c) -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = a[r][(c+r)%4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            if (mix) begin
                m[0] = xt(b[0][c]) ^ xt(b[1][c]) ^ b[1][c] ^ b[2][c] ^ b[3][c];
                m[1] = b[0][c] ^ xt(b[1][c]) ^ xt(b[2][c]) ^ b[2][c] ^ b[3][c];
                m[2] = b[0][c] ^ b[1][c] ^ xt(b[2][c]) ^ xt(b[3][c]) ^ b[3][c];
                m[3] = xt(b[0][c]) ^ b[0][c] ^ b[1][c] ^ b[2][c] ^ xt(b[3][c]);
            end else begin
                for (int r = 0; r < 4; r++) m[r] = b[r][c];
            end
            for (int r = 0; r < 4; r++) o[127-8*(r+4*c) -: 8] = m[r];
        end
        return o ^ rk;
    endfunction

    // Behavioural accelerator: per-word LD/ST, ENCI xors, ENCM/ENCF
    // collect the round key and apply the whole round on word 3.
    logic [31:0] m_st[4];
    logic [31:0] m_rk[4];
    logic [1:0]  m_idx;

    always @(posedge clk) begin
        logic [127:0] nx;
        if (!rst_n) begin
            m_idx <= 2'd0;
            m_out <= 32'd0;
        end else if (acc_start) begin
            m_idx <= m_idx + 2'd1;
            if (acc_op == 6'h00) begin
                m_st[m_idx] <= acc_data;
            end else if (acc_op == 6'h01) begin
                m_out <= m_st[m_idx];
            end else if (acc_op[2:0] == 3'b100) begin
                m_st[m_idx] <= m_st[m_idx] ^ acc_data;
            end else if (m_idx != 2'd3) begin
                m_rk[m_idx] <= acc_data;
            end else begin
                nx = aes_round({m_st[3], m_st[2], m_st[1], m_st[0]},
                               {acc_data, m_rk[2], m_rk[1], m_rk[0]},
                               acc_op[2:0] == 3'b101);
                for (int i = 0; i < 4; i++) m_st[i] <= nx[32*i +: 32];
            end
        end
    end

    task automatic build_sbox();
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (i != 0 && gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Expand key; RAM addr 4r+j holds FIPS word w[4r+3-j]
    task automatic load_key(input logic [127:0] key);
        logic [31:0] wk[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wk[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wk[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wk[i] = wk[i-4] ^ t;
        end
        for (int a = 0; a < 64; a++) kram[a] = 32'h0;
        for (int r = 0; r < 11; r++)
            for (int j = 0; j < 4; j++) kram[4*r+j] = wk[4*r+3-j];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] p, input logic [127:0] exp);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got %b exp 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        pt = p;
        acc_cyc = cyc;
        sb.push_back(exp);
        step();
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_busy got %b exp 1", busy);
        end
    endtask

    task automatic collect(input int hold);
        int n;
        logic [127:0] exp;
        logic [127:0] snap;
        bit stable;
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL res_timeout got %b exp 1", res_valid);
            return;
        end
        checks++;
        if (cyc - acc_cyc != 54) begin
            errors++;
            $display("FAIL latency got %0d exp 54", cyc - acc_cyc);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got result %h exp none", res);
        end else begin
            exp = sb.pop_front();
            if (res !== exp) begin
                errors++;
                $display("FAIL result got %h exp %h", res, exp);
            end
        end
        if (hold > 0) begin
            snap = res;
            stable = 1'b1;
            repeat (hold) begin
                step();
                if (res !== snap || res_valid !== 1'b1) stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL hold got %h/%b exp %h/1", res, res_valid, snap);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if ({req_ready, busy, res_valid} !== 3'b100) begin
            errors++;
            $display("FAIL to_idle got %b exp 100", {req_ready, busy, res_valid});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if ({req_ready, res_valid, busy, acc_start} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_flags got %b exp 1000",
                     {req_ready, res_valid, busy, acc_start});
        end
        checks++;
        if (acc_op !== 6'd0 || acc_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_acc got %h/%h exp 0/0", acc_op, acc_data);
        end
        checks++;
        if (key_addr !== 6'd0 || res !== 128'd0) begin
            errors++;
            $display("FAIL rst_out got %h/%h exp 0/0", key_addr, res);
        end
        step();
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle got %b%b exp 10", req_ready, busy);
        end
    endtask

    task automatic test_fips_trace();
        logic [127:0] p;
        logic [5:0]   eop;
        logic [31:0]  ed;
        logic [1:0]   w;
        p = 128'h3243f6a8_885a308d_313198a2_e0370734;
        t_op.delete();
        t_data.delete();
        t_addr.delete();
        trace_en = 1'b1;
        send(p, 128'h3925841d_02dc09fb_dc118597_196a0b32);
        collect(0);
        trace_en = 1'b0;
        checks++;
        if (t_op.size() != 52) begin
            errors++;
            $display("FAIL op_count got %0d exp 52", t_op.size());
        end
        for (int k = 0; k < 52 && k < t_op.size(); k++) begin
            w = 2'(k % 4);
            if (k < 4)       begin eop = 6'h00; ed = p[32*k +: 32]; end
            else if (k < 8)  begin eop = {1'b0, w, 3'b100}; ed = kram[k-4]; end
            else if (k < 44) begin eop = {1'b0, w, 3'b101}; ed = kram[k-4]; end
            else if (k < 48) begin eop = 6'h06; ed = kram[k-4]; end
            else             begin eop = 6'h01; ed = 32'h0; end
            checks++;
            if (t_op[k] !== eop || t_data[k] !== ed) begin
                errors++;
                $display("FAIL op_%0d got %h/%h exp %h/%h", k, t_op[k], t_data[k], eop, ed);
            end
            if (k >= 3 && k <= 46) begin
                checks++;
                if (t_addr[k] !== 6'(k - 3)) begin
                    errors++;
                    $display("FAIL kaddr_%0d got %0d exp %0d", k, t_addr[k], k - 3);
                end
            end
        end
    endtask

    task automatic test_zero();
        load_key(128'h0);
        send(128'h0, 128'h66e94bd4_ef8a2c3b_884cfa59_ca342b2e);
        collect(0);
        load_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    endtask

    task automatic test_back_to_back();
        int c0;
        send(128'h3243f6a8_885a308d_313198a2_e0370734,
             128'h3925841d_02dc09fb_dc118597_196a0b32);
        collect(20);
        c0 = cyc;
        send(128'h6bc1bee2_2e409f96_e93d7e11_7393172a,
             128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97);
        checks++;
        if (acc_cyc != c0) begin
            errors++;
            $display("FAIL b2b_accept got %0d exp %0d", acc_cyc, c0);
        end
        collect(0);
    endtask

    task automatic test_ignore();
        send(128'h3243f6a8_885a308d_313198a2_e0370734,
             128'h3925841d_02dc09fb_dc118597_196a0b32);
        repeat (19) step();
        pt = 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51;
        for (int i = 0; i < 6; i++) begin
            req_valid = (i % 2 == 0);
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL ign_ready got %b exp 0", req_ready);
            end
            step();
        end
        req_valid = 1'b0;
        collect(0);
    endtask

    task automatic test_reset_mid();
        send(128'h6bc1bee2_2e409f96_e93d7e11_7393172a,
             128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97);
        repeat (19) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        checks++;
        if ({req_ready, busy, acc_start, res_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_rst got %b exp 1000",
                     {req_ready, busy, acc_start, res_valid});
        end
        send(128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51,
             128'hf5d3d585_03b9699d_e785895a_96fdbaaf);
        collect(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        pt = '0;
        build_sbox();
        load_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
        test_reset();
        test_fips_trace();
        test_zero();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
